// File: rtl/cpu_pkg.sv
// Shared constants and types for the decode/execute boundary of the integer pipeline.
package cpu_pkg;

    localparam int XLEN  = 32;
    localparam int RAW   = 5;
    localparam int CNT_W = 16;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        BUBBLE = 2'd2
    } stage_state_e;

    // Control bits of the ID/EX register that must be cleared together on a bubble or flush.
    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
    } ex_ctrl_t;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Signal bundle between decode, register file, forwarding sources and the ID/EX stage.
interface id_ex_operand_stage_if
    import cpu_pkg::*;
#(
    parameter int XLEN  = cpu_pkg::XLEN,
    parameter int RAW   = cpu_pkg::RAW,
    parameter int CNT_W = cpu_pkg::CNT_W
);

    logic             id_valid;
    logic [RAW-1:0]   id_rs1;
    logic [RAW-1:0]   id_rs2;
    logic [RAW-1:0]   id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             id_use_imm;
    logic [XLEN-1:0]  id_imm;
    logic [3:0]       id_alu_op;

    logic [RAW-1:0]   rf_raddr1;
    logic [RAW-1:0]   rf_raddr2;
    logic [XLEN-1:0]  rf_rdata1;
    logic [XLEN-1:0]  rf_rdata2;

    logic [RAW-1:0]   m_rd;
    logic             m_reg_write;
    logic [XLEN-1:0]  m_result;
    logic [RAW-1:0]   w_rd;
    logic             w_reg_write;
    logic [XLEN-1:0]  w_data;

    logic             ex_busy;
    logic             flush;
    logic             id_stall;

    logic             ex_valid;
    logic [RAW-1:0]   ex_rd;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic [3:0]       ex_alu_op;
    logic [XLEN-1:0]  ex_op_a;
    logic [XLEN-1:0]  ex_op_b;
    logic [XLEN-1:0]  ex_store_data;
    logic [CNT_W-1:0] stall_count;

    // Pipeline side driving decode results and forwarding sources.
    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read,
               id_use_imm, id_imm, id_alu_op,
               rf_rdata1, rf_rdata2,
               m_rd, m_reg_write, m_result, w_rd, w_reg_write, w_data,
               ex_busy, flush,
        input  rf_raddr1, rf_raddr2, id_stall,
               ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_alu_op,
               ex_op_a, ex_op_b, ex_store_data, stall_count
    );

    // The operand stage itself.
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read,
               id_use_imm, id_imm, id_alu_op,
               rf_rdata1, rf_rdata2,
               m_rd, m_reg_write, m_result, w_rd, w_reg_write, w_data,
               ex_busy, flush,
        output rf_raddr1, rf_raddr2, id_stall,
               ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_alu_op,
               ex_op_a, ex_op_b, ex_store_data, stall_count
    );

endinterface

// File: rtl/operand_forward_mux.sv
// Selects one source operand: x0, EX/MEM result, MEM/WB write data, or register-file read data.
module operand_forward_mux
    import cpu_pkg::*;
#(
    parameter int XLEN = cpu_pkg::XLEN,
    parameter int RAW  = cpu_pkg::RAW
) (
    input  logic [RAW-1:0]  idx,
    input  logic [XLEN-1:0] rf_rdata,
    input  logic            m_reg_write,
    input  logic [RAW-1:0]  m_rd,
    input  logic [XLEN-1:0] m_result,
    input  logic            w_reg_write,
    input  logic [RAW-1:0]  w_rd,
    input  logic [XLEN-1:0] w_data,
    output logic [XLEN-1:0] operand
);

    // EX/MEM is the younger producer, so it outranks MEM/WB. The MEM/WB bypass is
    // required because the register file only commits w_data at the coming edge.
    always_comb begin
        // NOTE: assign a default first so every path drives 'operand'; otherwise a latch is inferred.
        operand = rf_rdata;
        if (idx == '0) begin
            operand = '0;
        end else if (m_reg_write && (m_rd == idx)) begin
            operand = m_result;
        end else if (w_reg_write && (w_rd == idx)) begin
            operand = w_data;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// Operand fetch with forwarding, load-use and busy stalls, flush, and the ID/EX pipeline register.
module id_ex_operand_stage
    import cpu_pkg::*;
#(
    parameter int XLEN  = cpu_pkg::XLEN,
    parameter int RAW   = cpu_pkg::RAW,
    parameter int CNT_W = cpu_pkg::CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    id_ex_operand_stage_if.slave bus
);

    stage_state_e     state;
    stage_state_e     state_nxt;
    ex_ctrl_t         ex_ctrl;
    ex_ctrl_t         id_ctrl;
    logic [RAW-1:0]   ex_rd;
    logic [3:0]       ex_alu_op;
    logic [XLEN-1:0]  ex_op_a;
    logic [XLEN-1:0]  ex_op_b;
    logic [XLEN-1:0]  ex_store_data;
    logic [CNT_W-1:0] stall_count;
    logic [XLEN-1:0]  fwd1;
    logic [XLEN-1:0]  fwd2;
    logic             load_use;
    logic             id_stall;

    assign bus.rf_raddr1 = bus.id_rs1;
    assign bus.rf_raddr2 = bus.id_rs2;

    operand_forward_mux #(.XLEN(XLEN), .RAW(RAW)) u_fwd1 (
        .idx         (bus.id_rs1),
        .rf_rdata    (bus.rf_rdata1),
        .m_reg_write (bus.m_reg_write),
        .m_rd        (bus.m_rd),
        .m_result    (bus.m_result),
        .w_reg_write (bus.w_reg_write),
        .w_rd        (bus.w_rd),
        .w_data      (bus.w_data),
        .operand     (fwd1)
    );

    operand_forward_mux #(.XLEN(XLEN), .RAW(RAW)) u_fwd2 (
        .idx         (bus.id_rs2),
        .rf_rdata    (bus.rf_rdata2),
        .m_reg_write (bus.m_reg_write),
        .m_rd        (bus.m_rd),
        .m_result    (bus.m_result),
        .w_reg_write (bus.w_reg_write),
        .w_rd        (bus.w_rd),
        .w_data      (bus.w_data),
        .operand     (fwd2)
    );

    // A bubble already sits in ID/EX while in BUBBLE, so never stack a second one.
    assign load_use = bus.id_valid && ex_ctrl.valid && ex_ctrl.mem_read
                   && (ex_rd != '0)
                   && ((ex_rd == bus.id_rs1) || (ex_rd == bus.id_rs2))
                   && (state != BUBBLE);

    always_comb begin
        state_nxt = RUN;
        if (bus.flush) begin
            state_nxt = RUN;
        end else if (bus.ex_busy) begin
            state_nxt = HOLD;
        end else if (load_use) begin
            state_nxt = BUBBLE;
        end
    end

    // Stalling is exactly "not going to RUN"; a flush always forces RUN.
    assign id_stall = (state_nxt != RUN);

    assign id_ctrl.valid     = bus.id_valid && !bus.flush;
    assign id_ctrl.reg_write = bus.id_valid && !bus.flush && bus.id_reg_write;
    assign id_ctrl.mem_read  = bus.id_valid && !bus.flush && bus.id_mem_read;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            ex_ctrl       <= '0;
            ex_rd         <= '0;
            ex_alu_op     <= '0;
            ex_op_a       <= '0;
            ex_op_b       <= '0;
            ex_store_data <= '0;
            stall_count   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_nxt;

            if (id_stall && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end

            case (state_nxt)
                HOLD: begin
                    ex_ctrl <= ex_ctrl;
                end
                BUBBLE: begin
                    ex_ctrl <= '0;
                end
                default: begin
                    ex_ctrl       <= id_ctrl;
                    ex_rd         <= bus.id_rd;
                    ex_alu_op     <= bus.id_alu_op;
                    ex_op_a       <= fwd1;
                    ex_op_b       <= bus.id_use_imm ? bus.id_imm : fwd2;
                    ex_store_data <= fwd2;
                end
            endcase
        end
    end

    assign bus.id_stall      = id_stall;
    assign bus.ex_valid      = ex_ctrl.valid;
    assign bus.ex_reg_write  = ex_ctrl.reg_write;
    assign bus.ex_mem_read   = ex_ctrl.mem_read;
    assign bus.ex_rd         = ex_rd;
    assign bus.ex_alu_op     = ex_alu_op;
    assign bus.ex_op_a       = ex_op_a;
    assign bus.ex_op_b       = ex_op_b;
    assign bus.ex_store_data = ex_store_data;
    assign bus.stall_count   = stall_count;

endmodule
